// File: rtl/perf_counter_bank.sv
// perf_counter_bank: cycle counter plus maskable event counters with overflow, snapshot and registered read
module perf_counter_bank #(
   parameter int NUM_EVT       = 4,
   parameter int CNT_W         = 32,
   parameter int SAT_MODE      = 0,
   parameter int FREEZE_ON_OVF = 0
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           cnt_en_i,
   input  logic [NUM_EVT-1:0]             evt_i,
   input  logic [NUM_EVT-1:0]             evt_mask_i,
   input  logic                           clr_i,
   input  logic                           snap_i,
   input  logic [$clog2(NUM_EVT+1)-1:0]   rd_sel_i,
   input  logic                           rd_shadow_i,
   output logic [CNT_W-1:0]               rd_data_o,
   output logic [NUM_EVT:0]               ovf_o,
   output logic                           frozen_o
);
   localparam int N  = NUM_EVT + 1;
   localparam int SW = $clog2(N);
   localparam logic [CNT_W-1:0] MAX = '1;
   localparam logic [CNT_W-1:0] ONE = CNT_W'(1);
   logic [CNT_W-1:0] r_cnt [N];
   logic [CNT_W-1:0] r_shd [N];
   logic [CNT_W-1:0] r_rd;
   logic [N-1:0]     r_ovf;
   logic             w_act;
   logic [N-1:0]     w_inc;
   logic [CNT_W-1:0] w_rd;
   assign w_act     = cnt_en_i & ~frozen_o;
   assign w_inc     = {evt_i & evt_mask_i & {NUM_EVT{w_act}}, w_act};
   assign ovf_o     = r_ovf;
   assign frozen_o  = (FREEZE_ON_OVF != 0) & (|r_ovf);
   assign rd_data_o = r_rd;
   // live counters, shadows and sticky overflow; clear wins over increment, snap sees pre-edge values
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < N; i++) begin
            r_cnt[i] <= '0;
            r_shd[i] <= '0;
         end
         r_ovf <= '0;
      end else begin
         for (int i = 0; i < N; i++) begin
            if (snap_i) r_shd[i] <= r_cnt[i];
            if (clr_i) begin
               r_cnt[i] <= '0;
               r_ovf[i] <= 1'b0;
            end else if (w_inc[i]) begin
               r_cnt[i] <= (r_cnt[i] == MAX) ? ((SAT_MODE != 0) ? MAX : '0) : r_cnt[i] + ONE;
               if (r_cnt[i] == MAX) r_ovf[i] <= 1'b1;
            end
         end
      end
   end
   // read mux over live or shadow bank; unused selects return zero
   always_comb begin
      w_rd = '0;
      for (int k = 0; k < N; k++)
         if (rd_sel_i == SW'(k)) w_rd = rd_shadow_i ? r_shd[k] : r_cnt[k];
   end
   // one-cycle registered read port
   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_rd <= '0;
      else     r_rd <= w_rd;
   end
endmodule

// File: tb/tb_perf_counter_bank.sv
// tb_perf_counter_bank: directed self-checking bench over four parameter sets
module tb_perf_counter_bank;
   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        cnt_en = 1'b0;
   logic [3:0]  evt = '0;
   logic [3:0]  mask = '0;
   logic        clr = 1'b0;
   logic        snap = 1'b0;
   logic [2:0]  sel = '0;
   logic        shd = 1'b0;
   logic [31:0] rd_a;
   logic [7:0]  rd_w, rd_s, rd_f;
   logic [4:0]  ovf_a, ovf_w, ovf_s, ovf_f;
   logic        frz_a, frz_w, frz_s, frz_f;
   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   perf_counter_bank dut_a (.clk(clk), .rst(rst), .cnt_en_i(cnt_en), .evt_i(evt), .evt_mask_i(mask),
      .clr_i(clr), .snap_i(snap), .rd_sel_i(sel), .rd_shadow_i(shd), .rd_data_o(rd_a), .ovf_o(ovf_a), .frozen_o(frz_a));
   perf_counter_bank #(.CNT_W(8), .SAT_MODE(0)) dut_w (.clk(clk), .rst(rst), .cnt_en_i(cnt_en), .evt_i(evt), .evt_mask_i(mask),
      .clr_i(clr), .snap_i(snap), .rd_sel_i(sel), .rd_shadow_i(shd), .rd_data_o(rd_w), .ovf_o(ovf_w), .frozen_o(frz_w));
   perf_counter_bank #(.CNT_W(8), .SAT_MODE(1)) dut_s (.clk(clk), .rst(rst), .cnt_en_i(cnt_en), .evt_i(evt), .evt_mask_i(mask),
      .clr_i(clr), .snap_i(snap), .rd_sel_i(sel), .rd_shadow_i(shd), .rd_data_o(rd_s), .ovf_o(ovf_s), .frozen_o(frz_s));
   perf_counter_bank #(.CNT_W(8), .FREEZE_ON_OVF(1)) dut_f (.clk(clk), .rst(rst), .cnt_en_i(cnt_en), .evt_i(evt), .evt_mask_i(mask),
      .clr_i(clr), .snap_i(snap), .rd_sel_i(sel), .rd_shadow_i(shd), .rd_data_o(rd_f), .ovf_o(ovf_f), .frozen_o(frz_f));

   task automatic tick(input int n = 1);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic rd(input logic [2:0] s, input logic sh);
      sel = s;
      shd = sh;
      tick();
   endtask

   task automatic test_reset();
      cnt_en = 0; evt = '0; mask = '0; clr = 0; snap = 0; sel = '0; shd = 0;
      rst = 1;
      #1;
      checks++;
      if (rd_a !== 32'd0 || ovf_a !== 5'd0 || frz_a !== 1'b0) begin
         failures++;
         $display("FAIL reset_a: rd=%0d ovf=%b frz=%b required 0/0/0", rd_a, ovf_a, frz_a);
      end
      checks++;
      if (rd_f !== 8'd0 || ovf_f !== 5'd0 || frz_f !== 1'b0) begin
         failures++;
         $display("FAIL reset_f: rd=%0d ovf=%b frz=%b required 0/0/0", rd_f, ovf_f, frz_f);
      end
      tick();
      rst = 0;
   endtask

   task automatic test_cycle_count();
      cnt_en = 1;
      tick(20);
      cnt_en = 0;
      rd(0, 0);
      checks++;
      if (rd_a !== 32'd20) begin
         failures++;
         $display("FAIL cycle20: got %0d required 20", rd_a);
      end
      for (int k = 1; k <= 4; k++) begin
         rd(3'(k), 0);
         checks++;
         if (rd_a !== 32'd0) begin
            failures++;
            $display("FAIL evt_idle[%0d]: got %0d required 0", k, rd_a);
         end
      end
      checks++;
      if (ovf_a !== 5'd0) begin
         failures++;
         $display("FAIL ovf_idle: got %b required 00000", ovf_a);
      end
   endtask

   task automatic test_events();
      mask = 4'b0001;
      cnt_en = 1;
      for (int i = 0; i < 7; i++) begin
         evt = 4'b0001; tick();
         evt = 4'b0000; tick();
      end
      for (int i = 0; i < 5; i++) begin
         evt = 4'b0010; tick();
         evt = 4'b0000; tick();
      end
      cnt_en = 0;
      rd(1, 0);
      checks++;
      if (rd_a !== 32'd7) begin
         failures++;
         $display("FAIL evt1_count: got %0d required 7", rd_a);
      end
      rd(2, 0);
      checks++;
      if (rd_a !== 32'd0) begin
         failures++;
         $display("FAIL evt2_masked: got %0d required 0", rd_a);
      end
      rd(0, 0);
      checks++;
      if (rd_a !== 32'd24) begin
         failures++;
         $display("FAIL cycle_evt: got %0d required 24", rd_a);
      end
   endtask

   task automatic test_overflow();
      cnt_en = 1;
      tick(256);
      cnt_en = 0;
      rd(0, 0);
      checks++;
      if (rd_w !== 8'd0 || ovf_w !== 5'b00001) begin
         failures++;
         $display("FAIL wrap: got %0d ovf=%b required 0 ovf=00001", rd_w, ovf_w);
      end
      checks++;
      if (rd_s !== 8'd255 || ovf_s !== 5'b00001) begin
         failures++;
         $display("FAIL sat: got %0d ovf=%b required 255 ovf=00001", rd_s, ovf_s);
      end
      checks++;
      if (rd_a !== 32'd256 || ovf_a !== 5'd0) begin
         failures++;
         $display("FAIL wide_no_ovf: got %0d ovf=%b required 256 ovf=00000", rd_a, ovf_a);
      end
      checks++;
      if (frz_f !== 1'b1 || frz_w !== 1'b0) begin
         failures++;
         $display("FAIL frozen_flag: got f=%b w=%b required f=1 w=0", frz_f, frz_w);
      end
   endtask

   task automatic test_freeze();
      mask = 4'b0001;
      evt = 4'b0001;
      cnt_en = 1;
      tick(10);
      cnt_en = 0;
      evt = '0;
      rd(0, 0);
      checks++;
      if (rd_f !== 8'd0 || frz_f !== 1'b1) begin
         failures++;
         $display("FAIL freeze_cycle: got %0d frz=%b required 0 frz=1", rd_f, frz_f);
      end
      rd(1, 0);
      checks++;
      if (rd_f !== 8'd0) begin
         failures++;
         $display("FAIL freeze_evt: got %0d required 0", rd_f);
      end
      checks++;
      if (rd_s !== 8'd10) begin
         failures++;
         $display("FAIL sat_evt_runs: got %0d required 10", rd_s);
      end
      clr = 1; tick(); clr = 0;
      checks++;
      if (ovf_f !== 5'd0 || frz_f !== 1'b0) begin
         failures++;
         $display("FAIL clr_unfreeze: got ovf=%b frz=%b required 00000/0", ovf_f, frz_f);
      end
      cnt_en = 1;
      tick(5);
      cnt_en = 0;
      rd(0, 0);
      checks++;
      if (rd_f !== 8'd5) begin
         failures++;
         $display("FAIL resume: got %0d required 5", rd_f);
      end
   endtask

   task automatic test_snap_clr();
      cnt_en = 1;
      tick(41);
      snap = 1; clr = 1;
      tick();
      snap = 0; clr = 0; cnt_en = 0;
      rd(0, 1);
      checks++;
      if (rd_a !== 32'd41) begin
         failures++;
         $display("FAIL snap_shadow: got %0d required 41", rd_a);
      end
      rd(0, 0);
      checks++;
      if (rd_a !== 32'd0) begin
         failures++;
         $display("FAIL clr_beats_inc: got %0d required 0", rd_a);
      end
   endtask

   task automatic test_bad_sel_and_async_reset();
      cnt_en = 1;
      tick(3);
      cnt_en = 0;
      rd(5, 0);
      checks++;
      if (rd_a !== 32'd0) begin
         failures++;
         $display("FAIL sel5: got %0d required 0", rd_a);
      end
      rd(7, 1);
      checks++;
      if (rd_a !== 32'd0) begin
         failures++;
         $display("FAIL sel7: got %0d required 0", rd_a);
      end
      rd(0, 0);
      checks++;
      if (rd_a !== 32'd3) begin
         failures++;
         $display("FAIL sel0_after: got %0d required 3", rd_a);
      end
      cnt_en = 1;
      tick(260);
      checks++;
      if (ovf_w !== 5'b00001 || rd_a === 32'd0) begin
         failures++;
         $display("FAIL pre_reset: ovf_w=%b rd_a=%0d required 00001 and nonzero", ovf_w, rd_a);
      end
      #2;
      rst = 1;
      #1;
      checks++;
      if (rd_a !== 32'd0 || rd_w !== 8'd0 || rd_s !== 8'd0 || ovf_w !== 5'd0 || ovf_s !== 5'd0 || ovf_f !== 5'd0 || frz_f !== 1'b0) begin
         failures++;
         $display("FAIL async_reset: rd_a=%0d rd_w=%0d rd_s=%0d ovf_w=%b ovf_s=%b ovf_f=%b frz_f=%b required all 0",
                  rd_a, rd_w, rd_s, ovf_w, ovf_s, ovf_f, frz_f);
      end
      cnt_en = 0;
      tick();
      rst = 0;
   endtask

   initial begin
      test_reset();
      test_cycle_count();
      test_reset();
      test_events();
      test_reset();
      test_overflow();
      test_freeze();
      test_reset();
      test_snap_clr();
      test_bad_sel_and_async_reset();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
